// File: rtl/smg_disp_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler.
package smg_disp_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] DEF_SRC  = 2'd0;
    localparam logic [7:0] RST_BYTE = 8'h00;

endpackage

// File: rtl/smg_rr_pick.sv
// Round-robin picker: first asserted req after last_src, wrapping modulo NUM_SRC.
module smg_rr_pick #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last_src,
    output logic [1:0]         winner,
    output logic               valid
);

    int idx;

    // Scan from the far end so the nearest requester is the last one written.
    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last_src) + k) % NUM_SRC;
            if (req[idx]) begin
                winner = 2'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smg_disp_sched.sv
// Time-shares the 2-digit hex display among NUM_SRC byte producers, round-robin.
// Optional SMG_SCHED_PREEMPT_EN lets source 0 abort a hold held by another source.
module smg_disp_sched
    import smg_disp_sched_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int HOLD_TICKS = 3,
    parameter int CNT_W      = 4
) (
    input  logic                 clk_1hz,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   req,
    input  logic [NUM_SRC*8-1:0] src_data,
    output logic [NUM_SRC-1:0]   ack,
    output logic [7:0]           disp_data,
    output logic [1:0]           disp_src,
    output logic                 disp_update,
    output logic                 busy
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   hold_cnt, hold_nx;
    logic [1:0]         last_src, last_nx;
    logic [7:0]         data_nx;
    logic [1:0]         src_nx;
    logic [NUM_SRC-1:0] ack_nx;
    logic               upd_nx;
    logic               busy_nx;
    logic               grant;
    logic [1:0]         gsrc;
    logic [1:0]         win;
    logic               win_vld;

    smg_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req      (req),
        .last_src (last_src),
        .winner   (win),
        .valid    (win_vld)
    );

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_src    <= 2'(NUM_SRC - 1);
            disp_data   <= RST_BYTE;
            disp_src    <= DEF_SRC;
            ack         <= '0;
            disp_update <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            last_src    <= last_nx;
            disp_data   <= data_nx;
            disp_src    <= src_nx;
            ack         <= ack_nx;
            disp_update <= upd_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        last_nx  = last_src;
        data_nx  = disp_data;
        src_nx   = disp_src;
        ack_nx   = '0;
        upd_nx   = 1'b0;
        grant    = 1'b0;
        gsrc     = win;

        unique case (state)
            IDLE: begin
                if (win_vld)
                    grant = 1'b1;
            end
            HOLD: begin
`ifdef SMG_SCHED_PREEMPT_EN
                if (disp_src != DEF_SRC && req[0]) begin
                    grant = 1'b1;
                    gsrc  = DEF_SRC;
                end else
`endif
                if (hold_cnt != '0)
                    hold_nx = hold_cnt - 1'b1;
                else if (win_vld)
                    grant = 1'b1;
                else
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (grant) begin
            state_nx = HOLD;
            hold_nx  = CNT_W'(HOLD_TICKS - 1);
            last_nx  = gsrc;
            data_nx  = src_data[int'(gsrc)*8 +: 8];
            src_nx   = gsrc;
            ack_nx   = NUM_SRC'(1) << gsrc;
            upd_nx   = 1'b1;
        end

        busy_nx = (state_nx == HOLD);
    end

endmodule
